// File: rtl/mem_lsu_pkg.sv
// ============================================================================
// Module   : mem_lsu_pkg
// Brief    : Shared pipeline types: ALU ops, LSU ops and LSU FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_lsu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef enum logic [2:0] {
        LSU_LB  = 3'd0,
        LSU_LBU = 3'd1,
        LSU_LH  = 3'd2,
        LSU_LHU = 3'd3,
        LSU_LW  = 3'd4,
        LSU_SB  = 3'd5,
        LSU_SH  = 3'd6,
        LSU_SW  = 3'd7
    } lsu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    function automatic logic lsu_is_store(lsu_op_t op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    function automatic lsu_size_t lsu_size(lsu_op_t op);
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: return SZ_BYTE;
            LSU_LH, LSU_LHU, LSU_SH: return SZ_HALF;
            default:                 return SZ_WORD;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lsu_lane.sv
// ============================================================================
// Module   : mem_lsu_lane
// Brief    : Byte-lane logic: alignment check, byte enables, store
//            replication and load extract/extend (purely combinational).
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_lsu_lane
    import mem_lsu_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic        o_misaligned,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data
);

    lsu_op_t   w_op;
    lsu_size_t w_size;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_op   = lsu_op_t'(i_op);
    assign w_size = lsu_size(w_op);
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    always_comb begin
        o_misaligned = 1'b0;
        case (w_size)
            SZ_HALF: o_misaligned = i_addr_lo[0];
            SZ_WORD: o_misaligned = (i_addr_lo != 2'b00);
            default: o_misaligned = 1'b0;
        endcase
    end

    // Loads always fetch the full word; lane selection happens on return.
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        case (w_op)
            LSU_SB: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            LSU_SH: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

    always_comb begin
        o_ld_data = i_rdata;
        case (w_op)
            LSU_LB:  o_ld_data = {{24{w_byte[7]}}, w_byte};
            LSU_LBU: o_ld_data = {24'd0, w_byte};
            LSU_LH:  o_ld_data = {{16{w_half[15]}}, w_half};
            LSU_LHU: o_ld_data = {16'd0, w_half};
            default: o_ld_data = i_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_lsu.sv
// ============================================================================
// Module   : mem_lsu
// Brief    : MEM-stage load/store unit driving a single-outstanding bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    input  logic        pipe_adv,
    output logic        stall_o,
    output logic        ld_valid_o,
    output logic [31:0] ld_data_o,
    output logic        exc_adel_o,
    output logic        exc_ades_o,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    lsu_state_t  r_state;
    lsu_op_t     r_op;
    logic [1:0]  r_addr_lo;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic        r_ld_valid;
    logic [31:0] r_ld_data;

    logic        w_idle;
    logic [2:0]  w_sel_op;
    logic [1:0]  w_sel_lo;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ld_data;
    logic        w_req_ok;
    logic        w_start;
    logic        w_req_store;

    // The lane block sees the incoming request while idle (alignment, bus
    // formatting) and the latched request otherwise (load extraction).
    assign w_idle   = (r_state == ST_IDLE);
    assign w_sel_op = w_idle ? req_op : r_op;
    assign w_sel_lo = w_idle ? req_addr[1:0] : r_addr_lo;

    mem_lsu_lane u_lsu_lane (
        .i_op         (w_sel_op),
        .i_addr_lo    (w_sel_lo),
        .i_wdata      (req_wdata),
        .i_rdata      (bus_rdata),
        .o_misaligned (w_misaligned),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_ld_data    (w_ld_data)
    );

    assign w_req_store = lsu_is_store(lsu_op_t'(req_op));
    assign w_req_ok    = w_idle && req_valid && !flush && !rst;
    assign w_start     = w_req_ok && !w_misaligned;

    assign exc_adel_o = w_req_ok && w_misaligned && !w_req_store;
    assign exc_ades_o = w_req_ok && w_misaligned &&  w_req_store;
    assign stall_o    = w_start || (r_state == ST_BUSY) || (r_state == ST_DRAIN);
    assign ld_valid_o = r_ld_valid && !flush;
    assign ld_data_o  = r_ld_data;
    assign bus_req    = r_bus_req;
    assign bus_we     = r_bus_we;
    assign bus_addr   = r_bus_addr;
    assign bus_be     = r_bus_be;
    assign bus_wdata  = r_bus_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= LSU_LB;
            r_addr_lo   <= 2'b00;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_be    <= 4'd0;
            r_bus_wdata <= 32'd0;
            r_ld_valid  <= 1'b0;
            r_ld_data   <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state     <= ST_BUSY;
                        r_op        <= lsu_op_t'(req_op);
                        r_addr_lo   <= req_addr[1:0];
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= w_req_store;
                        r_bus_addr  <= {req_addr[31:2], 2'b00};
                        r_bus_be    <= w_be;
                        r_bus_wdata <= w_wdata;
                    end
                end
                ST_BUSY: begin
                    if (bus_ack) begin
                        r_bus_req <= 1'b0;
                        if (flush) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state    <= ST_DONE;
                            r_ld_valid <= !lsu_is_store(r_op);
                            if (!lsu_is_store(r_op)) begin
                                r_ld_data <= w_ld_data;
                            end
                        end
                    end else if (flush) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    if (flush || pipe_adv) begin
                        r_state    <= ST_IDLE;
                        r_ld_valid <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (bus_ack) begin
                        r_state   <= ST_IDLE;
                        r_bus_req <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
